shift_sub_divider: RTL and testbench
====================================

Name: shift_sub_divider

Overview:
- Sequential restoring shift-subtract divider: the inverse of the team's shift-add multiplier/shifter datapath (4-bit operand in, 8-bit result out).
- Takes an 8-bit dividend and a 4-bit divisor, and returns an 8-bit quotient and a 4-bit remainder.
- One quotient bit per clock, with a start/busy/done handshake.
- Sits beside the shifter in the arithmetic datapath, so a multiplied product can be divided back down.

Parameters:
- DIVIDEND_W, 8: dividend and quotient width.
- DIVISOR_W, 4: divisor and remainder width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; synchronous, active-low.
- start  input  1  request; sampled on rising edge.
- dividend  input  DIVIDEND_W  numerator; captured when start is accepted.
- divisor  input  DIVISOR_W  denominator; captured when start is accepted.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse; results valid.
- quotient  output  DIVIDEND_W  result quotient.
- remainder  output  DIVISOR_W  result remainder.
- div_by_zero  output  1  set with done when the captured divisor is 0.

Behaviour:
- Reset (rst_n low at an edge): state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0; internal counter and registers cleared. This applies mid-operation too: the division is abandoned and no done pulse is issued.
- States:
  - IDLE: wait for start.
  - RUN: one iteration per clock.
  - FINISH: register results, pulse done.
- IDLE/FINISH -> RUN on start=1:
  - Capture operands.
  - Partial remainder P (DIVISOR_W+1 bits) = 0; Q = dividend; count = DIVIDEND_W-1; busy=1.
- RUN, each edge:
  - {P,Q} shift left 1.
  - T = P_shifted - {0,divisor}.
  - If T >= 0: P=T, Q[0]=1. Else P is kept (restore) and Q[0]=0.
  - count decrements. When count reaches 0 in RUN -> FINISH.
- FINISH, one cycle:
  - quotient=Q, remainder=P[DIVISOR_W-1:0], done=1, busy=0.
  - Next edge -> IDLE (done=0), or -> RUN if start=1 (back-to-back allowed).
- Latency: start accepted at edge E0 -> done high for exactly the cycle after edge E0+DIVIDEND_W+1. busy is high from after E0 until that same edge.
- start while busy (RUN): ignored, and operands are not re-captured.
- quotient, remainder and div_by_zero hold their values until the next FINISH or reset. They do not change during RUN.
- Divide by zero: the divisor is detected at capture. Timing is unchanged (constant latency). At FINISH: quotient = all ones, remainder = 0, div_by_zero = 1.
- div_by_zero is cleared at the next FINISH with a nonzero divisor.
- Arithmetic is unsigned by default. remainder < divisor is always guaranteed for a nonzero divisor.

Optional Feature:
- Macro: DIV_SIGNED_EN.
- Defined:
  - Operands are two's complement.
  - On capture, absolute values are taken; the unsigned core runs unchanged.
  - An extra SIGN_FIX state between RUN and FINISH applies the signs:
    - quotient negated if the operand signs differ;
    - remainder takes the dividend's sign (truncating division).
  - Latency becomes DIVIDEND_W+2 edges after acceptance.
  - Divide by zero: quotient = all ones (-1), remainder = 0, flag = 1.
- Undefined: unsigned only, no SIGN_FIX state, latency DIVIDEND_W+1.

Test Plan:
- Reset, then dividend=200, divisor=7, start for 1 cycle -> busy for 9 cycles; done pulse; quotient=28, remainder=4, div_by_zero=0.
- 255/15 -> quotient=17, remainder=0. Then 5/9 issued back-to-back in the FINISH cycle -> quotient=0, remainder=5, done exactly 9 cycles later.
- 100/0 -> done at normal latency; quotient=255, remainder=0, div_by_zero=1. Next 12/4 -> quotient=3, remainder=0, div_by_zero=0.
- Start 200/7, then assert start with 50/5 at cycle 3 -> ignored; result still 28 r 4 at the original done time, and no second done follows.
- Start 200/7, drive rst_n=0 at cycle 4 -> next edge: busy=0, quotient=0, remainder=0; no done pulse for the aborted operation.
- (DIV_SIGNED_EN) 0x9C (-100) / 7 -> quotient=0xF2 (-14), remainder=0xE (-2), done after 10 cycles. Also 100/-7 (0x9) -> quotient=0xF2, remainder=2.

Source files
------------

// File: rtl/shift_sub_divider.sv
// shift_sub_divider: sequential restoring shift-subtract divider.
// Divides a DIVIDEND_W-bit dividend by a DIVISOR_W-bit divisor, one quotient
// bit per clock, behind a start/busy/done handshake. The result registers hold
// their values between operations. A zero divisor still runs the full,
// constant-latency sequence. It then reports all-ones / zero and raises
// div_by_zero.
// Optional feature macro DIV_SIGNED_EN: with this macro defined, the operands
// are two's complement. The unsigned core runs on the magnitudes, and an extra
// SIGN_FIX state applies truncating-division signs before FINISH.
module shift_sub_divider #(
    parameter int DIVIDEND_W = 8,
    parameter int DIVISOR_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVIDEND_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

`ifdef DIV_SIGNED_EN
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        SIGN_FIX = 2'd2,
        FINISH   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;
`endif

    state_t                state;
    state_t                state_n;

    // Partial remainder P is one bit wider than the divisor, so the shifted
    // value can be compared against the divisor without overflow.
    logic [DIVISOR_W:0]    prem;
    logic [DIVISOR_W:0]    prem_n;
    logic [DIVIDEND_W-1:0] qreg;
    logic [DIVIDEND_W-1:0] qreg_n;
    logic [DIVISOR_W-1:0]  dvsr;
    logic [DIVISOR_W-1:0]  dvsr_n;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      count_n;
    logic                  zero_div;
    logic                  zero_div_n;

    logic                  busy_n;
    logic                  done_n;
    logic                  dbz_n;
    logic [DIVIDEND_W-1:0] quotient_n;
    logic [DIVISOR_W-1:0]  remainder_n;

    logic                  load;
    logic [DIVIDEND_W-1:0] cap_dividend;
    logic [DIVISOR_W-1:0]  cap_divisor;
    logic [DIVISOR_W:0]    prem_shift;
    logic [DIVIDEND_W-1:0] q_shift;
    logic [DIVISOR_W+1:0]  trial;

`ifdef DIV_SIGNED_EN
    logic                  neg_quot;
    logic                  neg_quot_n;
    logic                  neg_rem;
    logic                  neg_rem_n;
    logic [DIVIDEND_W-1:0] quot_neg;
    logic [DIVISOR_W-1:0]  rem_mag;
    logic [DIVISOR_W-1:0]  rem_neg;
`endif

    // Condition the operands for capture: the core always sees magnitudes
    always_comb begin
`ifdef DIV_SIGNED_EN
        cap_dividend = dividend[DIVIDEND_W-1] ? -dividend : dividend;
        cap_divisor  = divisor[DIVISOR_W-1]   ? -divisor  : divisor;
`else
        cap_dividend = dividend;
        cap_divisor  = divisor;
`endif
    end

    // One restoring step: shift {P,Q} left and trial-subtract the divisor (sign bit = borrow)
    always_comb begin
        prem_shift = {prem[DIVISOR_W-1:0], qreg[DIVIDEND_W-1]};
        q_shift    = {qreg[DIVIDEND_W-2:0], 1'b0};
        trial      = {prem, qreg[DIVIDEND_W-1]} - {2'b00, dvsr};
    end

`ifdef DIV_SIGNED_EN
    // Negated forms of the unsigned results, used when applying signs
    always_comb begin
        quot_neg = -qreg;
        rem_mag  = prem[DIVISOR_W-1:0];
        rem_neg  = -rem_mag;
    end
`endif

    // Next-state and next-register logic for the divider sequence
    always_comb begin
        state_n     = state;
        prem_n      = prem;
        qreg_n      = qreg;
        dvsr_n      = dvsr;
        count_n     = count;
        zero_div_n  = zero_div;
        busy_n      = busy;
        done_n      = 1'b0;
        dbz_n       = div_by_zero;
        quotient_n  = quotient;
        remainder_n = remainder;
`ifdef DIV_SIGNED_EN
        neg_quot_n  = neg_quot;
        neg_rem_n   = neg_rem;
`endif
        load        = start && ((state == IDLE) || (state == FINISH));

        case (state)
            IDLE: begin
                busy_n = 1'b0;
            end

            RUN: begin
                if (trial[DIVISOR_W+1]) begin
                    prem_n = prem_shift;
                    qreg_n = q_shift;
                end else begin
                    prem_n = trial[DIVISOR_W:0];
                    qreg_n = q_shift | {{(DIVIDEND_W-1){1'b0}}, 1'b1};
                end
                count_n = count - CNT_ONE;
                if (count == '0) begin
`ifdef DIV_SIGNED_EN
                    state_n = SIGN_FIX;
`else
                    state_n = FINISH;
`endif
                end
            end

`ifdef DIV_SIGNED_EN
            SIGN_FIX: begin
                if (neg_quot) begin
                    qreg_n = quot_neg;
                end
                if (neg_rem) begin
                    prem_n = {1'b0, rem_neg};
                end
                state_n = FINISH;
            end
`endif

            FINISH: begin
                quotient_n  = zero_div ? '1 : qreg;
                remainder_n = zero_div ? '0 : prem[DIVISOR_W-1:0];
                dbz_n       = zero_div;
                done_n      = 1'b1;
                busy_n      = 1'b0;
                state_n     = IDLE;
            end

            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
        endcase

        if (load) begin
            state_n    = RUN;
            busy_n     = 1'b1;
            prem_n     = '0;
            qreg_n     = cap_dividend;
            dvsr_n     = cap_divisor;
            count_n    = CNT_LAST;
            zero_div_n = (divisor == '0);
`ifdef DIV_SIGNED_EN
            neg_quot_n = dividend[DIVIDEND_W-1] ^ divisor[DIVISOR_W-1];
            neg_rem_n  = dividend[DIVIDEND_W-1];
`endif
        end
    end

    // State and datapath registers; reset abandons any division in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            prem        <= '0;
            qreg        <= '0;
            dvsr        <= '0;
            count       <= '0;
            zero_div    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
`ifdef DIV_SIGNED_EN
            neg_quot    <= 1'b0;
            neg_rem     <= 1'b0;
`endif
        end else begin
            state       <= state_n;
            prem        <= prem_n;
            qreg        <= qreg_n;
            dvsr        <= dvsr_n;
            count       <= count_n;
            zero_div    <= zero_div_n;
            busy        <= busy_n;
            done        <= done_n;
            div_by_zero <= dbz_n;
            quotient    <= quotient_n;
            remainder   <= remainder_n;
`ifdef DIV_SIGNED_EN
            neg_quot    <= neg_quot_n;
            neg_rem     <= neg_rem_n;
`endif
        end
    end

endmodule

// File: tb/tb_shift_sub_divider.sv
// tb_shift_sub_divider: self-checking bench for shift_sub_divider.
// Expected results are pushed to a scoreboard queue together with the cycle
// when done is due. A monitor pops and compares them when done pulses.
// Honours DIV_SIGNED_EN to select the signed expectations and latency.
module tb_shift_sub_divider;

    localparam int DW = 8;
    localparam int VW = 4;
`ifdef DIV_SIGNED_EN
    localparam int LAT = DW + 2;
`else
    localparam int LAT = DW + 1;
`endif
    localparam int NVEC = 13;

    typedef struct {
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        logic          z;
    } exp_t;

    typedef struct {
        logic [DW-1:0] a;
        logic [VW-1:0] b;
        exp_t          e;
    } vec_t;

    typedef struct {
        exp_t e;
        int   due;
    } sb_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] dividend = '0;
    logic [VW-1:0] divisor = '0;
    logic          busy;
    logic          done;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_by_zero;

    int   checks = 0;
    int   errors = 0;
    int   ncyc = 0;
    int   done_count = 0;
    sb_t  sbq[$];
    sb_t  mon_item;
    vec_t vecs[NVEC];

    // Free-running clock, 10 time units per period
    always #5 clk = ~clk;

    shift_sub_divider #(
        .DIVIDEND_W(DW),
        .DIVISOR_W (VW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk_vec(input logic [DW-1:0] a, input logic [VW-1:0] b,
                                    input logic [DW-1:0] q, input logic [VW-1:0] r, input logic z);
        vec_t v;
        v.a   = a;
        v.b   = b;
        v.e.q = q;
        v.e.r = r;
        v.e.z = z;
        return v;
    endfunction

    // Behavioural reference built on the language's own division operators
    function automatic exp_t model(input logic [DW-1:0] a, input logic [VW-1:0] b);
        exp_t e;
        int   sa;
        int   sb;
        int   qq;
        int   rr;
        if (b == '0) begin
            e.q = '1;
            e.r = '0;
            e.z = 1'b1;
        end else begin
`ifdef DIV_SIGNED_EN
            sa = int'($signed(a));
            sb = int'($signed(b));
`else
            sa = int'(a);
            sb = int'(b);
`endif
            qq  = sa / sb;
            rr  = sa % sb;
            e.q = qq[DW-1:0];
            e.r = rr[VW-1:0];
            e.z = 1'b0;
        end
        return e;
    endfunction

    // Drive one start request from just after a falling edge; optionally log the expectation
    task automatic applyStimulus(input logic [DW-1:0] a, input logic [VW-1:0] b,
                                 input exp_t e, input bit track);
        sb_t item;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        if (track) begin
            item.e   = e;
            item.due = ncyc + 1 + LAT;
            sbq.push_back(item);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDrain();
        int n = 0;
        while (sbq.size() != 0 && n < 4 * LAT) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout: got %0d outstanding expected 0", sbq.size());
            sbq.delete();
        end
    endtask

    // Monitor: on every done pulse, pop the scoreboard and compare values and timing
    always @(negedge clk) begin
        ncyc++;
        if (done === 1'b1) begin
            done_count++;
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done: got done at cycle %0d expected none", ncyc);
            end else begin
                mon_item = sbq.pop_front();
                checkOutput("quotient", quotient, mon_item.e.q);
                checkOutput("remainder", remainder, mon_item.e.r);
                checkOutput("div_by_zero", div_by_zero, mon_item.e.z);
                checkOutput("done_cycle", ncyc, mon_item.due);
            end
        end
    end

    // Safety net so the run always ends
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main test sequence
    initial begin
        int   n;
        int   d0;
        exp_t e0;

`ifdef DIV_SIGNED_EN
        vecs[0]  = mk_vec(8'h9C, 4'h7, 8'hF2, 4'hE, 1'b0);
        vecs[1]  = mk_vec(8'h64, 4'h9, 8'hF2, 4'h2, 1'b0);
        vecs[2]  = mk_vec(8'h9C, 4'h9, 8'h0E, 4'hE, 1'b0);
        vecs[3]  = mk_vec(8'h64, 4'h7, 8'h0E, 4'h2, 1'b0);
        vecs[4]  = mk_vec(8'h80, 4'hF, 8'h80, 4'h0, 1'b0);
        vecs[5]  = mk_vec(8'h7F, 4'h8, 8'hF1, 4'h7, 1'b0);
        vecs[6]  = mk_vec(8'h81, 4'h3, 8'hD6, 4'hF, 1'b0);
        vecs[7]  = mk_vec(8'h64, 4'h0, 8'hFF, 4'h0, 1'b1);
        vecs[8]  = mk_vec(8'h0C, 4'h4, 8'h03, 4'h0, 1'b0);
        vecs[9]  = mk_vec(8'h05, 4'h7, 8'h00, 4'h5, 1'b0);
        vecs[10] = mk_vec(8'hFB, 4'h7, 8'h00, 4'hB, 1'b0);
        vecs[11] = mk_vec(8'h00, 4'h5, 8'h00, 4'h0, 1'b0);
        vecs[12] = mk_vec(8'h0A, 4'hD, 8'hFD, 4'h1, 1'b0);
`else
        vecs[0]  = mk_vec(8'd200, 4'd7,  8'd28,  4'd4, 1'b0);
        vecs[1]  = mk_vec(8'd255, 4'd15, 8'd17,  4'd0, 1'b0);
        vecs[2]  = mk_vec(8'd5,   4'd9,  8'd0,   4'd5, 1'b0);
        vecs[3]  = mk_vec(8'd100, 4'd0,  8'd255, 4'd0, 1'b1);
        vecs[4]  = mk_vec(8'd12,  4'd4,  8'd3,   4'd0, 1'b0);
        vecs[5]  = mk_vec(8'd0,   4'd1,  8'd0,   4'd0, 1'b0);
        vecs[6]  = mk_vec(8'd255, 4'd1,  8'd255, 4'd0, 1'b0);
        vecs[7]  = mk_vec(8'd1,   4'd15, 8'd0,   4'd1, 1'b0);
        vecs[8]  = mk_vec(8'd128, 4'd3,  8'd42,  4'd2, 1'b0);
        vecs[9]  = mk_vec(8'd99,  4'd10, 8'd9,   4'd9, 1'b0);
        vecs[10] = mk_vec(8'd250, 4'd13, 8'd19,  4'd3, 1'b0);
        vecs[11] = mk_vec(8'd17,  4'd0,  8'd255, 4'd0, 1'b1);
        vecs[12] = mk_vec(8'd64,  4'd8,  8'd8,   4'd0, 1'b0);
`endif

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_quotient", quotient, 0);
        checkOutput("reset_remainder", remainder, 0);
        checkOutput("reset_dbz", div_by_zero, 0);
        rst_n = 1'b1;

        $display("[TB] busy length for 200/7");
        applyStimulus(8'd200, 4'd7, model(8'd200, 4'd7), 1'b1);
        checkOutput("busy_after_accept", busy, 1);
        n = 1;
        while (busy === 1'b1 && n < 4 * LAT) begin
            @(negedge clk);
            if (busy === 1'b1) n++;
        end
        checkOutput("busy_cycles", n, LAT);
        waitDrain();

        $display("[TB] back-to-back 255/15 then 5/9 from the FINISH cycle");
        e0 = model(8'd255, 4'd15);
        applyStimulus(8'd255, 4'd15, e0, 1'b1);
        repeat (LAT - 1) @(negedge clk);
        applyStimulus(8'd5, 4'd9, model(8'd5, 4'd9), 1'b1);
        repeat (3) @(negedge clk);
        checkOutput("quotient_hold_in_run", quotient, e0.q);
        checkOutput("remainder_hold_in_run", remainder, e0.r);
        checkOutput("busy_b2b", busy, 1);
        waitDrain();

        $display("[TB] start while busy is ignored");
        d0 = done_count;
        applyStimulus(8'd200, 4'd7, model(8'd200, 4'd7), 1'b1);
        repeat (2) @(negedge clk);
        dividend = 8'd50;
        divisor  = 4'd5;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDrain();
        repeat (2 * LAT) @(negedge clk);
        checkOutput("single_done_after_ignored_start", done_count, d0 + 1);

        $display("[TB] reset mid-operation");
        d0 = done_count;
        applyStimulus(8'd200, 4'd7, model(8'd200, 4'd7), 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_quotient", quotient, 0);
        checkOutput("abort_remainder", remainder, 0);
        checkOutput("abort_dbz", div_by_zero, 0);
        rst_n = 1'b1;
        repeat (2 * LAT) @(negedge clk);
        checkOutput("abort_no_done", done_count, d0);

        $display("[TB] vector table");
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].e, 1'b1);
            waitDrain();
        end

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
